// File: rtl/gen_support_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gen_support_pkg
// Description : Shared types and helpers for the gen_support merge sorter:
//               FSM state encoding, default parameter values and the
//               functions that derive the entry count and pass counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package gen_support_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned M_DEFAULT      = 13;
  localparam int unsigned SIGMA2_DEFAULT = 32;

  // Number of key slots for an index width of m bits.
  function automatic int unsigned num_entries(input int unsigned m);
    return 32'd1 << m;
  endfunction

  // Width of a counter able to hold the pass numbers 0..m.
  function automatic int unsigned pass_cnt_w(input int unsigned m);
    return $clog2(m + 1);
  endfunction

endpackage : gen_support_pkg
`default_nettype wire

// File: rtl/gen_support_dp_ram.sv
`default_nettype none
// ============================================================================
// Module      : gen_support_dp_ram
// Description : Simple dual-port RAM, 2**AW words of DW bits. One synchronous
//               write port and one read port whose data is registered
//               (read-first: a same-cycle write to the read address returns
//               the old word).
// Ports       : clk        - clock
//               wr_en_i    - write strobe
//               wr_addr_i  - write address
//               wr_data_i  - write data
//               rd_addr_i  - read address, sampled every cycle
//               rd_data_o  - registered read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module gen_support_dp_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule : gen_support_dp_ram
`default_nettype wire

// File: rtl/gen_support.sv
`default_nettype none
// ============================================================================
// Module      : gen_support
// Description : Stable ascending bottom-up merge sort of 2**M random keys.
//               Keys are loaded by address, sorted in M passes between two
//               ping-pong buffers, and read back by rank together with the
//               original load address of each key (the permutation).
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               wr_en     - load strobe (ignored while sorting)
//               wr_addr   - load address / tag of the loaded key
//               rand_in   - key to load
//               start     - begin a sort (ignored while sorting)
//               done      - one-cycle pulse after the final pass
//               rd_en     - result read strobe
//               rd_addr   - rank to read
//               rand_dout - key at rank rd_addr, 1-cycle latency, held
//               index_out - original address of that key
// Revision    : 1.0 - initial release
// ============================================================================
module gen_support
  import gen_support_pkg::*;
#(
  parameter int unsigned M      = M_DEFAULT,
  parameter int unsigned SIGMA2 = SIGMA2_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [M-1:0]      wr_addr,
  input  logic [SIGMA2-1:0] rand_in,
  input  logic              start,
  output logic              done,
  input  logic              rd_en,
  input  logic [M-1:0]      rd_addr,
  output logic [SIGMA2-1:0] rand_dout,
  output logic [M-1:0]      index_out
);

  localparam int unsigned N   = num_entries(M);
  localparam int unsigned PCW = pass_cnt_w(M);
  localparam int unsigned PW  = M + 1;       // pointers must reach N
  localparam int unsigned DW  = SIGMA2 + M;  // word = {key, tag}

  state_e          state_q, state_d;
  logic [PCW-1:0]  pass_q, pass_d;
  logic            prime_q, prime_d;
  logic            sel_q, sel_d;           // bank holding the live data
  logic [PW-1:0]   i_q, i_d;               // left-run head pointer
  logic [PW-1:0]   j_q, j_d;               // right-run head pointer
  logic [PW-1:0]   k_q, k_d;               // output pointer
  logic            rd_v_q;
  logic [SIGMA2-1:0] rand_dout_q;
  logic [M-1:0]      index_out_q;

  // --------------------------------------------------------------------------
  // Merge datapath
  // --------------------------------------------------------------------------
  logic              in_sort;
  logic [DW-1:0]     dout_l [2];
  logic [DW-1:0]     dout_r [2];
  logic [DW-1:0]     head_l, head_r;
  logic [SIGMA2-1:0] key_l, key_r;
  logic [M-1:0]      tag_l, tag_r;
  logic [PW-1:0]     run_len, blk_mask, blk_base, left_end, right_end;
  logic              left_exh, right_exh, take_l;
  logic [DW-1:0]     win_word;

  assign in_sort = (state_q == ST_SORT);

  assign head_l = dout_l[sel_q];
  assign head_r = dout_r[sel_q];
  assign key_l  = head_l[DW-1:M];
  assign key_r  = head_r[DW-1:M];
  // The first pass ignores stored tags: every slot is tagged with its
  // current address, so a re-sort of sorted data restarts the permutation.
  assign tag_l  = (pass_q == '0) ? i_q[M-1:0] : head_l[M-1:0];
  assign tag_r  = (pass_q == '0) ? j_q[M-1:0] : head_r[M-1:0];

  assign run_len   = PW'(1) << pass_q;
  assign blk_mask  = (run_len << 1) - 1'b1;
  assign blk_base  = k_q & ~blk_mask;
  assign left_end  = blk_base + run_len;
  assign right_end = blk_base + (run_len << 1);
  assign left_exh  = (i_q == left_end);
  assign right_exh = (j_q == right_end);
  // Ties go to the left run, which keeps the sort stable.
  assign take_l    = !left_exh && (right_exh || (key_l <= key_r));
  assign win_word  = take_l ? {key_l, tag_l} : {key_r, tag_r};

  // --------------------------------------------------------------------------
  // Ping-pong buffers: each bank has two identical copies so the left and
  // right run heads can be fetched in the same cycle.
  // --------------------------------------------------------------------------
  logic          we_any, wr_bank;
  logic [1:0]    ram_we;
  logic [M-1:0]  ram_waddr, raddr_l, raddr_r;
  logic [DW-1:0] ram_wdata;

  assign we_any    = in_sort ? !prime_q : wr_en;
  assign wr_bank   = in_sort ? ~sel_q : sel_q;
  assign ram_we[0] = we_any && !wr_bank;
  assign ram_we[1] = we_any && wr_bank;
  assign ram_waddr = in_sort ? k_q[M-1:0] : wr_addr;
  assign ram_wdata = in_sort ? win_word : {rand_in, wr_addr};
  // Read addresses come from the next-state pointers so the registered
  // RAM output presents the new heads exactly when they are needed.
  assign raddr_l   = in_sort ? i_d[M-1:0] : rd_addr;
  assign raddr_r   = j_d[M-1:0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    gen_support_dp_ram #(.AW(M), .DW(DW)) u_ram_l (
      .clk       (clk),
      .wr_en_i   (ram_we[b]),
      .wr_addr_i (ram_waddr),
      .wr_data_i (ram_wdata),
      .rd_addr_i (raddr_l),
      .rd_data_o (dout_l[b])
    );
    gen_support_dp_ram #(.AW(M), .DW(DW)) u_ram_r (
      .clk       (clk),
      .wr_en_i   (ram_we[b]),
      .wr_addr_i (ram_waddr),
      .wr_data_i (ram_wdata),
      .rd_addr_i (raddr_r),
      .rd_data_o (dout_r[b])
    );
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    prime_d = prime_q;
    sel_d   = sel_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SORT;
          pass_d  = '0;
          prime_d = 1'b1;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SORT: begin
        if (prime_q) begin
          // One cycle to fetch the first heads of a pass.
          i_d     = '0;
          j_d     = run_len;
          k_d     = '0;
          prime_d = 1'b0;
        end else begin
          if (take_l) begin
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          k_d = k_q + 1'b1;
          if ((k_q + 1'b1) == right_end) begin
            i_d = right_end;
            j_d = right_end + run_len;
          end
          if (k_q == PW'(N - 1)) begin
            sel_d = ~sel_q;
            if (pass_q == PCW'(M - 1)) begin
              state_d = ST_DONE;
            end else begin
              pass_d  = pass_q + 1'b1;
              prime_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pass_q  <= '0;
      prime_q <= 1'b0;
      sel_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      prime_q <= prime_d;
      sel_q   <= sel_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // --------------------------------------------------------------------------
  // Result read path: RAM read happens on the rd_en edge, the output
  // registers capture it one edge later and hold otherwise.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v_q      <= 1'b0;
      rand_dout_q <= '0;
      index_out_q <= '0;
    end else begin
      rd_v_q <= rd_en;
      if (rd_v_q) begin
        rand_dout_q <= head_l[DW-1:M];
        index_out_q <= head_l[M-1:0];
      end
    end
  end

  assign done      = (state_q == ST_DONE);
  assign rand_dout = rand_dout_q;
  assign index_out = index_out_q;

endmodule : gen_support
`default_nettype wire

// File: tb/tb_gen_support.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_support
// Description : Directed self-checking bench for gen_support (M=4, SIGMA2=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_support;

  localparam int M     = 4;
  localparam int S     = 8;
  localparam int N     = 16;
  localparam int BOUND = M * (N + 4) + 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [M-1:0] wr_addr;
  logic [S-1:0] rand_in;
  logic         start;
  logic         done;
  logic         rd_en;
  logic [M-1:0] rd_addr;
  logic [S-1:0] rand_dout;
  logic [M-1:0] index_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [S-1:0] keys  [N];
  logic [S-1:0] exp_k [N];
  logic [M-1:0] exp_i [N];
  logic [S-1:0] got_k [N];
  logic [M-1:0] got_i [N];

  gen_support #(.M(M), .SIGMA2(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rand_in   (rand_in),
    .start     (start),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rand_dout (rand_dout),
    .index_out (index_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_keys();
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      rand_in = keys[a];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Pulses start, waits (bounded) for done, optionally re-pulses start at
  // cycle restart_at, and checks that exactly one done pulse appears.
  task automatic run_sort(input string tag, input int restart_at);
    int cyc;
    int pulses;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; pulses = 0; seen = 1'b0;
    while (!seen && cyc < BOUND + 4) begin
      start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
        pulses++;
      end
    end
    start = 1'b0;
    check_eq({tag, " done seen"}, 32'(seen), 32'd1);
    check_eq({tag, " done within bound"}, 32'(cyc <= BOUND), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq({tag, " done pulse count"}, 32'(pulses), 32'd1);
  endtask

  task automatic read_rank(input int r, output logic [S-1:0] k, output logic [M-1:0] idx);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = 4'(r);
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    k   = rand_dout;
    idx = index_out;
  endtask

  task automatic read_all();
    for (int r = 0; r < N; r++) begin
      read_rank(r, got_k[r], got_i[r]);
    end
  endtask

  task automatic compare_table(input string tag);
    for (int r = 0; r < N; r++) begin
      check_eq($sformatf("%s rank%0d key", tag, r), 32'(got_k[r]), 32'(exp_k[r]));
      check_eq($sformatf("%s rank%0d index", tag, r), 32'(got_i[r]), 32'(exp_i[r]));
    end
  endtask

  task automatic set_descending();
    for (int a = 0; a < N; a++) keys[a] = 8'(N - 1 - a);
    for (int r = 0; r < N; r++) begin
      exp_k[r] = 8'(r);
      exp_i[r] = 4'(N - 1 - r);
    end
  endtask

  // Generic result properties: ordered (stable on ties), key matches the
  // key loaded at the reported index, indices form a permutation.
  task automatic check_properties(input string tag);
    logic [N-1:0] seen_mask;
    bit ok;
    seen_mask = '0;
    for (int r = 0; r < N; r++) begin
      seen_mask[got_i[r]] = 1'b1;
      check_eq($sformatf("%s rank%0d key matches load", tag, r), 32'(got_k[r]), 32'(keys[got_i[r]]));
      if (r < N - 1) begin
        ok = (got_k[r] < got_k[r+1]) || ((got_k[r] == got_k[r+1]) && (got_i[r] < got_i[r+1]));
        check_eq($sformatf("%s rank%0d stable order", tag, r), 32'(ok), 32'd1);
      end
    end
    check_eq({tag, " permutation"}, 32'(seen_mask), 32'hFFFF);
  endtask

  initial begin
    logic [S-1:0] k;
    logic [M-1:0] idx;
    int pulses;
    logic [S-1:0] tab_k [N];
    logic [M-1:0] tab_i [N];
    logic [S-1:0] tab_in [N];

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; rand_in = '0;
    start = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset rand_dout", 32'(rand_dout), 32'd0);
    check_eq("reset index_out", 32'(index_out), 32'd0);

    // Reverse-ordered keys.
    set_descending();
    load_keys();
    run_sort("desc", -1);
    read_all();
    compare_table("desc");

    // Write after done replaces rank 3, tag becomes 3; output holds.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd3; rand_in = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    read_rank(3, k, idx);
    check_eq("postwrite key", 32'(k), 32'hEE);
    check_eq("postwrite index", 32'(idx), 32'd3);
    rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("hold key", 32'(rand_dout), 32'hEE);
    check_eq("hold index", 32'(index_out), 32'd3);

    // Re-sort current contents: slot r holds r except slot 3 holds 0xEE.
    for (int r = 0; r < N; r++) begin
      exp_k[r] = (r < 3) ? 8'(r) : (r < N - 1) ? 8'(r + 1) : 8'hEE;
      exp_i[r] = (r < 3) ? 4'(r) : (r < N - 1) ? 4'(r + 1) : 4'd3;
    end
    run_sort("resort", -1);
    read_all();
    compare_table("resort");

    // Already sorted keys -> identity.
    for (int a = 0; a < N; a++) begin
      keys[a] = 8'(a); exp_k[a] = 8'(a); exp_i[a] = 4'(a);
    end
    load_keys();
    run_sort("asc", -1);
    read_all();
    compare_table("asc");

    // All-equal keys -> identity permutation.
    for (int a = 0; a < N; a++) begin
      keys[a] = 8'h5A; exp_k[a] = 8'h5A; exp_i[a] = 4'(a);
    end
    load_keys();
    run_sort("equal", -1);
    read_all();
    compare_table("equal");

    // Duplicates with a second start pulse during SORT.
    tab_in = '{8'd7, 8'd3, 8'd7, 8'd1, 8'd9, 8'd3, 8'd0, 8'd7,
               8'd1, 8'd1, 8'd15, 8'd3, 8'd7, 8'd0, 8'd2, 8'd9};
    tab_k  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3,
               8'd3, 8'd7, 8'd7, 8'd7, 8'd7, 8'd9, 8'd9, 8'd15};
    tab_i  = '{4'd6, 4'd13, 4'd3, 4'd8, 4'd9, 4'd14, 4'd1, 4'd5,
               4'd11, 4'd0, 4'd2, 4'd7, 4'd12, 4'd4, 4'd15, 4'd10};
    for (int a = 0; a < N; a++) begin
      keys[a] = tab_in[a]; exp_k[a] = tab_k[a]; exp_i[a] = tab_i[a];
    end
    load_keys();
    run_sort("restart", 10);
    read_all();
    compare_table("restart");

    // Asynchronous reset in the middle of a sort.
    set_descending();
    load_keys();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst done", 32'(done), 32'd0);
    check_eq("midrst rand_dout", 32'(rand_dout), 32'd0);
    check_eq("midrst index_out", 32'(index_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < BOUND + 10; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("midrst aborted no done", 32'(pulses), 32'd0);
    for (int a = 0; a < N; a++) keys[a] = 8'(8'h30 + 8'(N - 1 - a));
    for (int r = 0; r < N; r++) begin
      exp_k[r] = 8'(8'h30 + 8'(r));
      exp_i[r] = 4'(N - 1 - r);
    end
    load_keys();
    run_sort("afterrst", -1);
    read_all();
    compare_table("afterrst");

    // Random keys with many ties.
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < N; a++) keys[a] = 8'($urandom_range(0, 5));
      load_keys();
      run_sort($sformatf("rand%0d", t), -1);
      read_all();
      check_properties($sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gen_support
`default_nettype wire

// File: doc/gen_support.md
GEN_SUPPORT -- requirements
Module: gen_support

Interface
REQ-001 Parameter M, default 13: log2 of element count; N = 2^M entries; index width.
REQ-002 Parameter SIGMA2, default 32: width of each random sort key.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 wr_en  in  1  load strobe; writes rand_in into key slot wr_addr.
REQ-006 wr_addr  in  M  load address.
REQ-007 rand_in  in  SIGMA2  key to load.
REQ-008 start  in  1  one-cycle pulse that begins the sort.
REQ-009 done  out  1  one-cycle pulse when the sort completes.
REQ-010 rd_en  in  1  result read strobe.
REQ-011 rd_addr  in  M  result rank to read.
REQ-012 rand_dout  out  SIGMA2  key at rank rd_addr after sorting.
REQ-013 index_out  out  M  original load address of the key at rank rd_addr (the permutation).

Function
REQ-014 FSM states: IDLE, SORT, DONE; SORT spans M bottom-up merge passes.
REQ-015 IDLE: wr_en=1 writes rand_in to slot wr_addr in the same cycle; the slot's tag is the load address wr_addr.
REQ-016 start in IDLE or DONE -> SORT; start while in SORT is ignored.
REQ-017 wr_en while in SORT is ignored.
REQ-018 Sort order is ascending unsigned by key.
REQ-019 The sort is stable: equal keys keep increasing original index.
REQ-020 Pass p (p=0..M-1) merges runs of length 2^p into runs of length 2^(p+1), using ping-pong buffers.
REQ-021 Each pass takes N+4 cycles or fewer.
REQ-022 done pulses exactly one cycle after the final pass, and no later than M*(N+4)+8 cycles after start.
REQ-023 DONE -> IDLE on the cycle after the done pulse.
REQ-024 Read path: rd_en=1 at edge k returns the rank-rd_addr key and tag on rand_dout/index_out after edge k+1 (1-cycle latency).
REQ-025 rand_dout and index_out are registered and hold their value when rd_en=0.
REQ-026 Reads while in SORT return unspecified data and do not disturb the sort.
REQ-027 After done, result ranks 0..N-1 form a permutation of 0..N-1 in index_out.
REQ-028 A write after done overwrites result rank wr_addr and sets its tag to wr_addr.
REQ-029 A new start sorts the current contents; the tag of every slot is its current address.
REQ-030 Boundary conditions: wrap of wr_addr/rd_addr from N-1 to 0 is natural modulo; all-equal keys yield the identity permutation.

Reset
REQ-031 rst forces IDLE, done=0, rand_dout=0, index_out=0 immediately, including mid-sort (the sort is aborted).
REQ-032 Memory contents are not cleared by rst; after rst, a full reload plus start is required.

Structure
REQ-033 A shared package holds the FSM state enum and derived constants (N, pass counter width clog2(M+1)).
REQ-034 One sub-module, dp_ram (1 write port, 1 registered read port, parameterized depth/width), instantiated for the key and tag ping-pong buffers.

Verification (M=4, SIGMA2=8 unless noted)
REQ-035 Load keys 15..0 into addresses 0..15, start -> done within 4*20+8 cycles; rank r reads key r, index 15-r.
REQ-036 Load keys equal to address (already sorted), start -> identity permutation, rand_dout[r]=r.
REQ-037 Load all keys 0x5A, start -> index_out[r]=r for all r (stability); all rand_dout=0x5A.
REQ-038 Keys {7,3,7,1,...}, then pulse start again during SORT -> a single done pulse; result unaffected.
REQ-039 Assert rst mid-SORT -> done stays 0, outputs 0; reload and start -> correct result.
REQ-040 M=13, SIGMA2=32, random keys -> rand_dout is nondecreasing, index_out is a permutation, and rand_dout[r] equals the key loaded at address index_out[r].
